// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings and the
// channel-index width helper used by the mux and its arbiter.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first requester at or after ptr, wrapping
// modulo N, and returns it as a one-hot vector.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin
// arbitration and a single registered output stage.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     rr_gnt;
    logic [N-1:0]     fix_gnt;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             load_en;
    logic             any_gnt;

    rr_arbiter #(.N(N)) u_arb (
        .req (in_valid),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    // Out-of-range sel values simply leave the fixed grant empty.
    always_comb begin
        fix_gnt = '0;
        if (int'(sel) < N)
            fix_gnt[sel] = in_valid[sel];
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++)
            if (gnt[i])
                gnt_idx = SEL_W'(i);
    end

    assign gnt      = (mode == MODE_RR) ? rr_gnt : fix_gnt;
    assign any_gnt  = |gnt;
    assign load_en  = !out_valid || out_ready;
    assign in_ready = (load_en && !rst) ? gnt : '0;

    // Output register stage: the granted word lands here one cycle after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (any_gnt) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                out_chan  <= gnt_idx;
                if (mode == MODE_RR)
                    ptr <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n (N=4, WIDTH=32): directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_stream_mux_n;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } word_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [1:0]       sel;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic [1:0]       out_chan;
    logic             out_valid;
    logic             out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    word_t        sb[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_chan  = 0;
    int           m_ptr   = 0;
    logic         armed   = 1'b0;

    stream_mux_n #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = lowest circular distance from ptr among the valid channels.
    function automatic int model_grant(input logic m, input logic [1:0] s,
                                       input logic [N-1:0] v, input int p);
        int best  = -1;
        int bestd = N;
        if (m == 1'b0)
            return v[s] ? int'(s) : -1;
        for (int c = 0; c < N; c++) begin
            if (v[c] && ((c - p + N) % N) < bestd) begin
                bestd = (c - p + N) % N;
                best  = c;
            end
        end
        return best;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step(input logic r, input logic m, input logic [1:0] s,
                        input logic [N-1:0] v, input logic rdy, input logic [N*W-1:0] d);
        logic       le;
        int         g;
        logic [N-1:0] exp_rdy;
        word_t      w;
        @(negedge clk);
        rst = r; mode = m; sel = s; in_valid = v; out_ready = rdy; in_data = d;
        #1;
        le      = !m_valid || rdy;
        g       = r ? -1 : model_grant(m, s, v, m_ptr);
        exp_rdy = (le && g >= 0) ? (N'(1) << g) : '0;
        if (armed) begin
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            if (!m_valid) begin
                chk("out_data_hold", 64'(out_data), 64'(m_data));
                chk("out_chan_hold", 64'(out_chan), 64'(m_chan));
            end
        end
        if (r) begin
            m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
            sb.delete();
            armed = 1'b1;
        end else if (le) begin
            if (g >= 0) begin
                w.d = d[g*W +: W];
                w.c = g;
                sb.push_back(w);
                m_valid = 1'b1; m_data = w.d; m_chan = g;
                if (m) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Monitor: a word leaves whenever out_valid && out_ready just before the edge.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            #3;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_underflow: got word %h chan %0d expected none", out_data, out_chan);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_chan", 64'(out_chan), 64'(e.c));
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] dd;
        logic           r, rdy;
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0; in_data = '0;

        step(1, 0, 0, 4'b0000, 0, '0);
        step(1, 0, 0, 4'b1111, 1, rand_data());
        step(0, 0, 0, 4'b0000, 1, '0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_chan", 64'(out_chan), 64'h0);

        // Fixed select of channel 2.
        dd = {32'h33333333, 32'hCCCCCCCC, 32'h11111111, 32'h00000000};
        step(0, 0, 2, 4'b0100, 1, dd);
        chk("fixed_ready", 64'(in_ready), 64'h4);
        step(0, 0, 2, 4'b0000, 1, dd);
        chk("fixed_data", 64'(out_data), 64'hCCCCCCCC);
        chk("fixed_chan", 64'(out_chan), 64'h2);

        // Round-robin with all channels valid.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 4'b1111, 1, rand_data());

        // Backpressure with AAAAAAAA held.
        step(0, 0, 0, 4'b0001, 1, {96'h0, 32'hAAAAAAAA});
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 4'b0001, 0, {96'h0, 32'h12345678});
            chk("bp_hold", 64'(out_data), 64'hAAAAAAAA);
        end
        step(0, 0, 0, 4'b0001, 1, {96'h0, 32'h12345678});
        chk("bp_resume_ready", 64'(in_ready), 64'h1);
        step(0, 0, 0, 4'b0000, 1, '0);
        chk("bp_resume_data", 64'(out_data), 64'h12345678);

        // Drive ptr to 3, then request 0 and 1 only.
        step(0, 1, 0, 4'b0100, 1, rand_data());
        step(0, 1, 0, 4'b0011, 1, rand_data());
        chk("rr_wrap_ready", 64'(in_ready), 64'h1);
        step(0, 1, 0, 4'b0011, 1, rand_data());
        chk("rr_ptr1_ready", 64'(in_ready), 64'h2);

        // Fixed sel=1 with channel 1 idle: no grant, output drains.
        step(0, 0, 1, 4'b1101, 1, rand_data());
        step(0, 0, 1, 4'b1101, 1, rand_data());
        step(0, 0, 1, 4'b1101, 1, rand_data());

        // Reset while a word is held under backpressure.
        step(0, 0, 3, 4'b1000, 1, rand_data());
        step(0, 0, 3, 4'b1000, 0, rand_data());
        step(1, 0, 3, 4'b1000, 0, rand_data());
        step(0, 1, 0, 4'b1111, 1, rand_data());
        chk("rst_mid_chan", 64'(out_chan), 64'h0);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 59) == 0);
            rdy = r ? 1'b0 : ($urandom_range(0, 3) != 0);
            step(r, 1'($urandom), 2'($urandom), 4'($urandom), rdy, rand_data());
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0000, 1, '0);
        @(negedge clk);
        #4;
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
